// File: rtl/sub4_serial.sv
// Bit-serial W-bit subtractor d = a - b - bi, LSB first, behind a start/done handshake.
// Optional two's-complement overflow output enabled by SUB4_SERIAL_OVF_EN.
module sub4_serial #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo
`ifdef SUB4_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic [W-2:0]   acc;
  logic           br;
  logic [CW-1:0]  cnt;

  logic           last_bit_c;
  logic           accept_c;
  logic           shift_c;
  logic           diff_c;
  logic           br_nxt_c;
  logic [W-1:0]   res_nxt_c;

`ifdef SUB4_SERIAL_OVF_EN
  logic           a_msb;
  logic           b_msb;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last_bit_c = (cnt == CW'(W - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit_c) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the state register
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    unique case (state)
      IDLE:    accept_c = start;
      RUN: begin
        busy    = 1'b1;
        shift_c = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        accept_c = start;
      end
      default: ;
    endcase
  end

  // One-bit full subtractor on the operand LSBs
  always_comb begin
    diff_c    = sa[0] ^ sb[0] ^ br;
    br_nxt_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nxt_c = {diff_c, acc};
  end

  // Shift registers, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      acc <= '0;
      br  <= 1'b0;
      cnt <= '0;
      d   <= '0;
      bo  <= 1'b0;
`ifdef SUB4_SERIAL_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (accept_c) begin
      sa  <= a;
      sb  <= b;
      br  <= bi;
      acc <= '0;
      cnt <= '0;
`ifdef SUB4_SERIAL_OVF_EN
      a_msb <= a[W-1];
      b_msb <= b[W-1];
`endif
    end else if (shift_c) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= res_nxt_c[W-1:1];
      br  <= br_nxt_c;
      cnt <= cnt + CW'(1);
      if (last_bit_c) begin
        d  <= res_nxt_c;
        bo <= br_nxt_c;
`ifdef SUB4_SERIAL_OVF_EN
        ovf <= (a_msb != b_msb) && (diff_c != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial: directed vectors, exhaustive sweep and random ops
// against an arithmetic reference model.
module tb_sub4_serial;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SUB4_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] last_d;
  logic         last_bo;
  logic         last_ovf;

  sub4_serial #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SUB4_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on the integer values
  function automatic logic [W-1:0] ref_d(input int ra, input int rb, input int rbi);
    int r;
    r = (ra - rb - rbi) % (1 << W);
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_bo(input int ra, input int rb, input int rbi);
    return (ra < rb + rbi);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic [W-1:0] rd);
    return (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] ta,
                              input logic [W-1:0] tb_, input logic tbi);
    logic [W-1:0] ed;
    ed = ref_d(int'(ta), int'(tb_), int'(tbi));
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_bo"}, 32'(bo), 32'(ref_bo(int'(ta), int'(tb_), int'(tbi))));
`ifdef SUB4_SERIAL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(ta, tb_, ed)));
    last_ovf = ref_ovf(ta, tb_, ed);
`endif
    last_d  = ed;
    last_bo = ref_bo(int'(ta), int'(tb_), int'(tbi));
  endtask

  // Wait for done with a cycle budget; returns edges waited
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // One full operation from IDLE: accept, latency, hold during RUN, result, done pulse width
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi,
                        input string tag);
    int lat;
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold_d"}, 32'(d), 32'(last_d));
    check({tag, "_hold_bo"}, 32'(bo), 32'(last_bo));
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_result(tag, ta, tb_, tbi);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int lat;
    int extra;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    last_d = '0; last_bo = 1'b0; last_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bo", 32'(bo), 32'd0);
`ifdef SUB4_SERIAL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_op(4'b0101, 4'b0011, 1'b0, "single");
    check("single_d_const", 32'(d), 32'h2);
    run_op(4'b0011, 4'b0101, 1'b0, "borrow1");
    check("borrow1_bo_const", 32'(bo), 32'h1);
    run_op(4'b0000, 4'b0000, 1'b1, "borrow2");
    check("borrow2_d_const", 32'(d), 32'hf);
    run_op(4'b1111, 4'b1111, 1'b1, "borrow3");
    run_op(4'b0111, 4'b1000, 1'b0, "ovf1");
`ifdef SUB4_SERIAL_OVF_EN
    check("ovf1_const", 32'(ovf), 32'h1);
`endif

    // Start pulse during busy is ignored
    a = 4'b0110; b = 4'b0010; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'b1000; b = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign_lat", 32'(lat), 32'(W));
    check_result("ign", 4'b0110, 4'b0010, 1'b0);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("ign_no_second_done", 32'(extra), 32'd0);

    // Back-to-back: start held through DONE
    a = 4'b0101; b = 4'b0011; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 4'b0011; b = 4'b0101; bi = 1'b0;
    wait_done(lat);
    t1 = cyc;
    check_result("b2b1", 4'b0101, 4'b0011, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy2", 32'(busy), 32'd1);
    wait_done(lat);
    t2 = cyc;
    check("b2b_spacing", 32'(t2 - t1), 32'(W + 1));
    check_result("b2b2", 4'b0011, 4'b0101, 1'b0);
    @(posedge clk); #1;

    // Reset asserted two cycles into RUN
    a = 4'b1001; b = 4'b0100; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_d", 32'(d), 32'd0);
    check("mid_rst_bo", 32'(bo), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_d = '0; last_bo = 1'b0; last_ovf = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("mid_rst_no_done", 32'(extra), 32'd0);
    run_op(4'b1001, 4'b0100, 1'b0, "post_rst");

    // Exhaustive sweep of every (a, b, bi) vector
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      run_op(W'(i >> (W + 1)), W'(i >> 1), 1'(i), "sweep");
    end

    // Random operations with random idle gaps
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
